// File: rtl/mem_wb_skid_pkg.sv
// Shared types and defaults for the MEM->WB boundary register.
// The state encoding is {main_v, skid_v}, so the valid bits read straight out of the state.
package mem_wb_skid_pkg;

    localparam int LANES_DEF = 2;
    localparam int AW_DEF    = 5;
    localparam int DW_DEF    = 32;

    localparam logic [AW_DEF-1:0] ZERO_ADDR = '0;
    localparam logic [DW_DEF-1:0] ZERO_WORD = '0;

    typedef struct packed {
        logic              we;
        logic [AW_DEF-1:0] waddr;
        logic [DW_DEF-1:0] wdata;
    } wb_lane_t;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        TWO   = 2'b11
    } state_t;

endpackage

// File: rtl/mem_wb_skid_if.sv
// Valid/ready bundle of LANES GPR write lanes; lane i occupies slice i of each flat vector.
interface mem_wb_skid_if
    import mem_wb_skid_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) ();

    logic                  valid;
    logic                  ready;
    logic [LANES-1:0]      we;
    logic [LANES*AW-1:0]   waddr;
    logic [LANES*DW-1:0]   wdata;

    modport master (output valid, we, waddr, wdata, input ready);
    modport slave  (input valid, we, waddr, wdata, output ready);

endinterface

// File: rtl/wb_bundle_sanitize.sv
// Drops $zero writes and lets the youngest lane win a same-address conflict.
module wb_bundle_sanitize
    import mem_wb_skid_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic [LANES-1:0]    we,
    input  logic [LANES*AW-1:0] waddr,
    output logic [LANES-1:0]    we_clean
);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        we_clean = '0;
        for (int i = 0; i < LANES; i++) begin
            we_clean[i] = we[i] && (waddr[i*AW +: AW] != ZERO_ADDR[AW-1:0]);
            // A younger match with a nonzero address implies that younger lane survives.
            for (int j = i + 1; j < LANES; j++) begin
                if (we[j] && (waddr[j*AW +: AW] == waddr[i*AW +: AW])) begin
                    we_clean[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/mem_wb_skid.sv
// MEM->WB boundary register: main entry drives WB, a one-entry skid buffer absorbs back-pressure.
module mem_wb_skid
    import mem_wb_skid_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    mem_wb_skid_if.slave   mem,
    mem_wb_skid_if.master  wb
);

    state_t state_q, state_d;

    logic                main_v, skid_v;
    logic                accept, consume;
    logic                load_main_in, load_skid_in, load_main_skid;
    logic [LANES-1:0]    in_we_clean;

    logic [LANES-1:0]    main_we,    skid_we;
    logic [LANES*AW-1:0] main_waddr, skid_waddr;
    logic [LANES*DW-1:0] main_wdata, skid_wdata;

    wb_bundle_sanitize #(.LANES(LANES), .AW(AW)) u_sanitize (
        .we       (mem.we),
        .waddr    (mem.waddr),
        .we_clean (in_we_clean)
    );

    assign main_v  = state_q[1];
    assign skid_v  = state_q[0];
    assign accept  = mem.valid & mem.ready & ~flush;
    assign consume = main_v & wb.ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_skid_in   = 1'b0;
        load_main_skid = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) begin
                    state_d      = ONE;
                    load_main_in = 1'b1;
                end
                ONE: begin
                    if (accept && consume) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_d      = TWO;
                        load_skid_in = 1'b1;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end
                end
                TWO: if (consume) begin
                    state_d        = ONE;
                    load_main_skid = 1'b1;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: the payload registers are reset too, because WB must read all-zero address/data after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            main_we    <= '0;
            main_waddr <= '0;
            main_wdata <= '0;
            skid_we    <= '0;
            skid_waddr <= '0;
            skid_wdata <= '0;
        end else begin
            if (load_main_in) begin
                main_we    <= in_we_clean;
                main_waddr <= mem.waddr;
                main_wdata <= mem.wdata;
            end else if (load_main_skid) begin
                main_we    <= skid_we;
                main_waddr <= skid_waddr;
                main_wdata <= skid_wdata;
            end
            if (load_skid_in) begin
                skid_we    <= in_we_clean;
                skid_waddr <= mem.waddr;
                skid_wdata <= mem.wdata;
            end
        end
    end

    assign mem.ready = ~skid_v;
    assign wb.valid  = main_v;
    assign wb.we     = main_we & {LANES{main_v}};
    assign wb.waddr  = main_waddr;
    assign wb.wdata  = main_wdata;

endmodule

// File: tb/tb_mem_wb_skid.sv
// Self-checking bench for mem_wb_skid: directed scenarios plus a randomized run
// against a queue-based occupancy model of the boundary register.
module tb_mem_wb_skid;
    import mem_wb_skid_pkg::*;

    localparam int LANES = 2;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef wb_lane_t [LANES-1:0] bundle_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;

    mem_wb_skid_if #(.LANES(LANES), .AW(AW), .DW(DW)) mem_if ();
    mem_wb_skid_if #(.LANES(LANES), .AW(AW), .DW(DW)) wb_if ();

    mem_wb_skid #(.LANES(LANES), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .mem   (mem_if),
        .wb    (wb_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: queue of held bundles (front = what WB sees); capacity two.
    bundle_t q[$];
    bundle_t held = '0;
    int      model_cons = 0;
    int      dut_cons   = 0;

    logic                exp_valid, exp_ready;
    logic [LANES-1:0]    exp_we;
    logic [LANES*AW-1:0] exp_waddr;
    logic [LANES*DW-1:0] exp_wdata;

    function automatic bundle_t sanitize(bundle_t b);
        bit      claimed[int];
        bundle_t r = b;
        for (int i = LANES - 1; i >= 0; i--) begin
            r[i].we = b[i].we && (b[i].waddr != 0) && !claimed.exists(int'(b[i].waddr));
            if (r[i].we) claimed[int'(b[i].waddr)] = 1'b1;
        end
        return r;
    endfunction

    function automatic bundle_t mk(bit we0, int a0, logic [31:0] d0, bit we1, int a1, logic [31:0] d1);
        bundle_t b;
        b[0].we = we0; b[0].waddr = AW'(a0); b[0].wdata = d0;
        b[1].we = we1; b[1].waddr = AW'(a1); b[1].wdata = d1;
        return b;
    endfunction

    function automatic void update_expect();
        exp_valid = (q.size() > 0);
        exp_ready = (q.size() < 2);
        for (int i = 0; i < LANES; i++) begin
            exp_we[i]              = exp_valid ? held[i].we : 1'b0;
            exp_waddr[i*AW +: AW]  = held[i].waddr;
            exp_wdata[i*DW +: DW]  = held[i].wdata;
        end
    endfunction

    task automatic drive(bit v, bundle_t b);
        mem_if.valid = v;
        for (int i = 0; i < LANES; i++) begin
            mem_if.we[i]             = b[i].we;
            mem_if.waddr[i*AW +: AW] = b[i].waddr;
            mem_if.wdata[i*DW +: DW] = b[i].wdata;
        end
    endtask

    // One clock: model decides from pre-edge inputs, then outputs are sampled at the falling edge.
    task automatic tick();
        bit      acc, con;
        bundle_t inb;
        acc = mem_if.valid && (q.size() < 2) && !flush;
        con = (q.size() > 0) && wb_if.ready;
        for (int i = 0; i < LANES; i++) begin
            inb[i].we    = mem_if.we[i];
            inb[i].waddr = mem_if.waddr[i*AW +: AW];
            inb[i].wdata = mem_if.wdata[i*DW +: DW];
        end
        if (wb_if.valid === 1'b1 && wb_if.ready === 1'b1) dut_cons++;
        if (con) model_cons++;
        @(posedge clk);
        if (flush) begin
            q.delete();
            held = '0;
        end else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back(sanitize(inb));
            if (q.size() > 0) held = q[0];
        end
        @(negedge clk);
        update_expect();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (wb_if.valid !== 1'b0 || wb_if.we !== '0 || wb_if.wdata !== '0 || mem_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_init got v=%b we=%b d=%h rdy=%b exp v=0 we=0 d=0 rdy=1",
                     wb_if.valid, wb_if.we, wb_if.wdata, mem_if.ready);
        end
        rst = 1'b0;
        wb_if.ready = 1'b0;
        drive(1'b1, mk(1, 3, 32'hDEAD_BEEF, 0, 0, 0));
        tick();
        checks++;
        if (wb_if.valid !== 1'b1 || wb_if.wdata[31:0] !== 32'hDEAD_BEEF || wb_if.we !== 2'b01) begin
            errors++;
            $display("FAIL reset_load got v=%b we=%b d=%h exp v=1 we=01 d=deadbeef",
                     wb_if.valid, wb_if.we, wb_if.wdata[31:0]);
        end
        drive(1'b0, '0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (wb_if.valid !== 1'b0 || wb_if.we !== '0 || wb_if.wdata !== '0 || mem_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_async got v=%b we=%b d=%h rdy=%b exp v=0 we=0 d=0 rdy=1",
                     wb_if.valid, wb_if.we, wb_if.wdata, mem_if.ready);
        end
        q.delete();
        held = '0;
        #1 rst = 1'b0;
        @(negedge clk);
        update_expect();
    endtask

    task automatic test_stream();
        logic [31:0] d;
        wb_if.ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d = 32'h1111_1111 * (k + 1);
            drive(1'b1, mk(1, 3, d, 0, $urandom_range(0, 31), $urandom));
            tick();
            checks++;
            if (wb_if.valid !== 1'b1 || wb_if.we !== 2'b01 || wb_if.wdata[31:0] !== d ||
                wb_if.waddr[4:0] !== 5'd3 || mem_if.ready !== 1'b1 || wb_if.wdata !== exp_wdata) begin
                errors++;
                $display("FAIL stream_%0d got v=%b we=%b a=%h d=%h rdy=%b exp v=1 we=01 a=03 d=%h rdy=1",
                         k, wb_if.valid, wb_if.we, wb_if.waddr[4:0], wb_if.wdata[31:0], mem_if.ready, d);
            end
        end
        drive(1'b0, '0);
        tick();
        checks++;
        if (wb_if.valid !== 1'b0 || wb_if.we !== 2'b00) begin
            errors++;
            $display("FAIL stream_nodup got v=%b we=%b exp v=0 we=00", wb_if.valid, wb_if.we);
        end
    endtask

    task automatic test_back_pressure();
        wb_if.ready = 1'b0;
        drive(1'b1, mk(1, 4, 32'h0000_00AA, 0, 0, 0));
        tick();
        drive(1'b1, mk(1, 5, 32'h0000_00BB, 0, 0, 0));
        tick();
        checks++;
        if (mem_if.ready !== 1'b0 || wb_if.wdata[31:0] !== 32'hAA) begin
            errors++;
            $display("FAIL bp_full got rdy=%b d=%h exp rdy=0 d=aa", mem_if.ready, wb_if.wdata[31:0]);
        end
        drive(1'b1, mk(1, 6, 32'h0000_00CC, 0, 0, 0));
        tick();
        checks++;
        if (mem_if.ready !== 1'b0 || wb_if.valid !== 1'b1 || wb_if.wdata[31:0] !== 32'hAA) begin
            errors++;
            $display("FAIL bp_hold got v=%b rdy=%b d=%h exp v=1 rdy=0 d=aa",
                     wb_if.valid, mem_if.ready, wb_if.wdata[31:0]);
        end
        drive(1'b0, '0);
        wb_if.ready = 1'b1;
        tick();
        checks++;
        if (mem_if.ready !== 1'b1 || wb_if.valid !== 1'b1 || wb_if.wdata[31:0] !== 32'hBB || wb_if.waddr[4:0] !== 5'd5) begin
            errors++;
            $display("FAIL bp_drain_b got v=%b rdy=%b a=%h d=%h exp v=1 rdy=1 a=05 d=bb",
                     wb_if.valid, mem_if.ready, wb_if.waddr[4:0], wb_if.wdata[31:0]);
        end
        tick();
        checks++;
        if (wb_if.valid !== 1'b0 || wb_if.we !== 2'b00 || mem_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_empty got v=%b we=%b rdy=%b exp v=0 we=00 rdy=1",
                     wb_if.valid, wb_if.we, mem_if.ready);
        end
    endtask

    task automatic test_sanitize();
        wb_if.ready = 1'b1;
        drive(1'b1, mk(1, 0, 32'h5, 1, 7, 32'h9));
        tick();
        checks++;
        if (wb_if.we !== 2'b10 || wb_if.valid !== 1'b1 || wb_if.wdata[31:0] !== 32'h5) begin
            errors++;
            $display("FAIL san_zero got v=%b we=%b d0=%h exp v=1 we=10 d0=5",
                     wb_if.valid, wb_if.we, wb_if.wdata[31:0]);
        end
        drive(1'b1, mk(1, 7, 32'h1, 1, 7, 32'h2));
        tick();
        checks++;
        if (wb_if.we !== 2'b10 || wb_if.wdata[63:32] !== 32'h2 || wb_if.wdata[31:0] !== 32'h1 || wb_if.waddr !== {5'd7, 5'd7}) begin
            errors++;
            $display("FAIL san_conflict got we=%b a=%h d=%h exp we=10 a=0e7 d=0000000200000001",
                     wb_if.we, wb_if.waddr, wb_if.wdata);
        end
        drive(1'b0, '0);
        tick();
    endtask

    task automatic test_flush();
        wb_if.ready = 1'b0;
        drive(1'b1, mk(1, 9, 32'h0000_0F01, 1, 10, 32'h0000_0F02));
        tick();
        drive(1'b1, mk(1, 11, 32'h0000_0F03, 0, 0, 0));
        tick();
        drive(1'b1, mk(1, 12, 32'h0000_0F04, 0, 0, 0));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (wb_if.valid !== 1'b0 || wb_if.we !== 2'b00 || mem_if.ready !== 1'b1 || wb_if.wdata !== '0 || wb_if.waddr !== '0) begin
            errors++;
            $display("FAIL flush_two got v=%b we=%b rdy=%b a=%h d=%h exp v=0 we=00 rdy=1 a=0 d=0",
                     wb_if.valid, wb_if.we, mem_if.ready, wb_if.waddr, wb_if.wdata);
        end
        drive(1'b0, '0);
        wb_if.ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (wb_if.valid !== 1'b0 || wb_if.we !== 2'b00) begin
                errors++;
                $display("FAIL flush_gone_%0d got v=%b we=%b exp v=0 we=00", k, wb_if.valid, wb_if.we);
            end
        end
    endtask

    task automatic test_flush_consume();
        int c0;
        wb_if.ready = 1'b1;
        drive(1'b1, mk(1, 13, 32'h0000_C0DE, 0, 0, 0));
        tick();
        c0 = dut_cons;
        drive(1'b0, '0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
        checks++;
        if (dut_cons - c0 !== 1 || wb_if.valid !== 1'b0 || mem_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_consume got writes=%0d v=%b rdy=%b exp writes=1 v=0 rdy=1",
                     dut_cons - c0, wb_if.valid, mem_if.ready);
        end
    endtask

    task automatic test_random();
        bundle_t b;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < LANES; i++) begin
                b[i].we    = $urandom_range(0, 3) != 0;
                b[i].waddr = AW'($urandom_range(0, 3));
                b[i].wdata = $urandom;
            end
            drive($urandom_range(0, 9) < 7, b);
            wb_if.ready = $urandom_range(0, 9) < 6;
            flush = $urandom_range(0, 24) == 0;
            tick();
            checks++;
            if (wb_if.valid !== exp_valid || wb_if.we !== exp_we || wb_if.waddr !== exp_waddr ||
                wb_if.wdata !== exp_wdata || mem_if.ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_%0d got v=%b we=%b a=%h d=%h rdy=%b exp v=%b we=%b a=%h d=%h rdy=%b",
                         n, wb_if.valid, wb_if.we, wb_if.waddr, wb_if.wdata, mem_if.ready,
                         exp_valid, exp_we, exp_waddr, exp_wdata, exp_ready);
            end
        end
        flush = 1'b0;
        drive(1'b0, '0);
        checks++;
        if (dut_cons !== model_cons) begin
            errors++;
            $display("FAIL rand_writes got %0d exp %0d", dut_cons, model_cons);
        end
    endtask

    initial begin
        mem_if.valid = 1'b0;
        mem_if.we    = '0;
        mem_if.waddr = '0;
        mem_if.wdata = '0;
        wb_if.ready  = 1'b0;
        test_reset();
        test_stream();
        test_back_pressure();
        test_sanitize();
        test_flush();
        test_flush_consume();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_skid.md
Name: mem_wb_skid

Overview:
- Parametrised MEM→WB boundary register for multi-issue pipelines.
- Carries LANES parallel GPR write bundles (write enable, address, data).
- Replaces the fixed STALL vector with a valid/ready handshake and a one-entry skid buffer, so full throughput is kept under back-pressure.
- Adds flush and per-bundle write sanitising: no $zero writes, and a younger lane wins a same-address conflict. Sits between the memory stage and the register-file write port/forwarding network.

Parameters:
- LANES, 2, number of write lanes per bundle; lane 0 is the oldest instruction.
- AW, 5, GPR address width.
- DW, 32, GPR data width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- FLUSH  in  1  discard all held and incoming bundles this cycle.
- IN_VALID  in  1  MEM stage presents a bundle.
- IN_READY  out  1  block can accept a bundle; registered.
- IN_WE  in  LANES  per-lane write enable.
- IN_WADDR  in  LANES*AW  per-lane address; lane i at bits [i*AW +: AW].
- IN_WDATA  in  LANES*DW  per-lane data; lane i at bits [i*DW +: DW].
- OUT_VALID  out  1  WB bundle valid.
- OUT_READY  in  1  WB/register file consumes the bundle.
- OUT_WE  out  LANES  sanitised write enables; all 0 whenever OUT_VALID=0.
- OUT_WADDR  out  LANES*AW  held address.
- OUT_WDATA  out  LANES*DW  held data.

Behaviour:
- Storage:
  - main entry drives the outputs.
  - skid entry holds one bundle.
  - state = {main_v, skid_v}; the only legal values are 00, 10, 11.
- Reset (asynchronous, any time, including mid-transfer):
  - main_v=0, skid_v=0, all stored WE/WADDR/WDATA=0.
  - OUT_VALID=0, OUT_WE=0, IN_READY=1.
- IN_READY = ~skid_v, registered; never combinationally dependent on OUT_READY.
- Acceptance: accept = IN_VALID & IN_READY & ~FLUSH. Consumption: consume = main_v & OUT_READY.
- Transitions (evaluated on each rising edge, FLUSH=0):
  - 00: accept → 10, main loads input. Latency is 1 cycle: OUT_VALID rises the edge after accept.
  - 10: accept & consume → 10, main loads input (1 bundle/cycle throughput). Accept & ~consume → 11, skid loads input. ~accept & consume → 00. Otherwise hold.
  - 11: accept is impossible. Consume → 10, main loads skid, and IN_READY returns to 1 on the same edge. Otherwise hold.
- FLUSH (priority over everything except RST):
  - next state 00; stored WE cleared; WADDR/WDATA cleared to 0.
  - A bundle presented the same cycle is dropped; a bundle consumed the same cycle still counts as consumed by WB.
- Sanitise, applied at capture so stored WE is already clean:
  - WE[i]=0 if WADDR[i]==0.
  - WE[i]=0 if any younger lane j>i has a surviving WE[j]=1 with WADDR[j]==WADDR[i].
  - Data and address are stored unmodified.
- Stalls with no input (IN_VALID=0) insert no bundle; output is held, never duplicated.
- An all-WE-zero bundle is still a valid bundle; it is handshaked normally.

Decomposition:
- Shared package (extend the existing defines package):
  - LANES/AW/DW defaults.
  - zero-address and zero-word constants.
  - packed struct wb_lane_t {we, waddr, wdata}.
  - state enum {EMPTY, ONE, TWO}.
- One combinational sub-module, wb_bundle_sanitize (parametrised LANES/AW), for the $zero and same-address masking. The top level holds the two entries and the FSM.

Test Plan:
1. Reset mid-stream: state ONE with WDATA=0xDEAD_BEEF, assert RST asynchronously between edges → OUT_VALID, OUT_WE and OUT_WDATA drop to 0 immediately; IN_READY=1.
2. Streaming, OUT_READY=1: 4 bundles on consecutive cycles, lane0 {1, r3, 0x11..} → each appears exactly 1 cycle later; IN_READY stays 1; no bundle lost or duplicated.
3. Back-pressure: with main full, OUT_READY=0 for 3 cycles while IN_VALID=1 → skid fills, IN_READY=0 from the next edge; OUT_READY=1 → bundles drain in order A, B; IN_READY=1 after the first consume edge.
4. Sanitise: lanes {we=1, addr=0, 0x5} and {we=1, addr=7, 0x9} → OUT_WE=2'b10. Lanes {1, r7, 0x1} and {1, r7, 0x2} → OUT_WE=2'b10, OUT_WDATA lane1=0x2.
5. Flush in state TWO with IN_VALID=1 → next cycle OUT_VALID=0, OUT_WE=0, IN_READY=1; the flushed bundles never appear.
6. Flush and consume same cycle in state ONE → the consumed bundle counts as written exactly once; state EMPTY afterwards.
